// File: rtl/dma_desc_scheduler.sv
// Round-robin descriptor scheduler in front of a single DMA engine: one descriptor in flight, per-channel completion pulse.
// Optional WAIT watchdog under DMA_SCHED_TIMEOUT_EN (TIMEOUT_CYCLES limit); default build waits indefinitely.
module dma_desc_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req_valid_i,
    output logic [NUM_CH-1:0]              req_ready_o,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_src_addr_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_dst_addr_i,
    input  logic [NUM_CH*LEN_WIDTH-1:0]    req_num_bytes_i,
    output logic                           dma_go_o,
    output logic [ADDR_WIDTH-1:0]          dma_src_addr_o,
    output logic [ADDR_WIDTH-1:0]          dma_dst_addr_o,
    output logic [LEN_WIDTH-1:0]           dma_num_bytes_o,
    input  logic                           dma_done_i,
    input  logic                           dma_error_i,
    output logic [NUM_CH-1:0]              cpl_valid_o,
    output logic                           cpl_error_o,
    output logic                           cpl_timeout_o,
    output logic                           busy_o,
    output logic [$clog2(NUM_CH)-1:0]      grant_id_o
);
    localparam int IDW = $clog2(NUM_CH);
    localparam int IW  = IDW + 1;

    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("dma_desc_scheduler: unsupported NUM_CH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CPL} state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         rr_q, rr_d, grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]  src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   err_q, err_d;
    logic                   found;
    logic [IDW-1:0]         win;
`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   tmo_q, tmo_d;
`endif

    // First valid channel at or after rr_q, wrapping past NUM_CH-1.
    always_comb begin : rr_search
        logic [IW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_q} + IW'(i);
            if (idx >= IW'(NUM_CH)) idx = idx - IW'(NUM_CH);
            if (!found && req_valid_i[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        err_d   = err_q;
`ifdef DMA_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    src_d   = req_src_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    dst_d   = req_dst_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    len_d   = req_num_bytes_i[int'(win)*LEN_WIDTH +: LEN_WIDTH];
                    grant_d = win;
                    rr_d    = (win == IDW'(NUM_CH - 1)) ? '0 : win + 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                    if (len_d == '0) begin
                        err_d   = 1'b1;
                        state_d = S_CPL;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LAUNCH;
                    end
                end
            end
            // Status is not sampled here so a level left over from the previous transfer is not mistaken for completion.
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (dma_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_CPL;
                end else if (dma_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_CPL;
                end
`ifdef DMA_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_CPL;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            S_CPL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            err_q   <= err_d;
`ifdef DMA_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Ready is combinational from the request vector, so it is masked while reset is held.
    assign req_ready_o     = (state_q == S_IDLE && found && !rst) ?
                             ({{(NUM_CH-1){1'b0}}, 1'b1} << win) : '0;
    assign dma_go_o        = (state_q == S_LAUNCH);
    assign dma_src_addr_o  = src_q;
    assign dma_dst_addr_o  = dst_q;
    assign dma_num_bytes_o = len_q;
    assign cpl_valid_o     = (state_q == S_CPL) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign cpl_error_o     = (state_q == S_CPL) && err_q;
`ifdef DMA_SCHED_TIMEOUT_EN
    assign cpl_timeout_o   = (state_q == S_CPL) && tmo_q;
`else
    assign cpl_timeout_o   = 1'b0;
`endif
    assign busy_o          = (state_q != S_IDLE);
    assign grant_id_o      = grant_q;
endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Bench for dma_desc_scheduler: directed and random descriptors checked against a round-robin/latency reference model.
module tb_dma_desc_scheduler;
    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int TMO = 16;
`ifdef DMA_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid_i, req_ready_o, cpl_valid_o;
    logic [NCH*AW-1:0] req_src_addr_i, req_dst_addr_i;
    logic [NCH*LW-1:0] req_num_bytes_i;
    logic              dma_go_o, dma_done_i, dma_error_i;
    logic [AW-1:0]     dma_src_addr_o, dma_dst_addr_o;
    logic [LW-1:0]     dma_num_bytes_o;
    logic              cpl_error_o, cpl_timeout_o, busy_o;
    logic [1:0]        grant_id_o;

    logic [31:0] src_m [NCH];
    logic [31:0] dst_m [NCH];
    logic [31:0] len_m [NCH];
    int rr_m;
    int tests;
    int fails;

    always #5 clk = ~clk;

    dma_desc_scheduler #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_src_addr_i(req_src_addr_i), .req_dst_addr_i(req_dst_addr_i),
        .req_num_bytes_i(req_num_bytes_i),
        .dma_go_o(dma_go_o), .dma_src_addr_o(dma_src_addr_o), .dma_dst_addr_o(dma_dst_addr_o),
        .dma_num_bytes_o(dma_num_bytes_o), .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
        .cpl_valid_o(cpl_valid_o), .cpl_error_o(cpl_error_o), .cpl_timeout_o(cpl_timeout_o),
        .busy_o(busy_o), .grant_id_o(grant_id_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [NCH-1:0] m, input int rr);
        for (int i = 0; i < NCH; i++)
            if (m[(rr + i) % NCH]) return (rr + i) % NCH;
        return -1;
    endfunction

    task automatic rand_payloads(input bit zero_ok);
        for (int c = 0; c < NCH; c++) begin
            src_m[c] = $urandom;
            dst_m[c] = $urandom;
            len_m[c] = $urandom;
            if (len_m[c] == 0) len_m[c] = 1;
            if (zero_ok && $urandom_range(0, 5) == 0) len_m[c] = 0;
        end
    endtask

    task automatic drive_payloads();
        for (int c = 0; c < NCH; c++) begin
            req_src_addr_i[c*AW +: AW]  = src_m[c];
            req_dst_addr_i[c*AW +: AW]  = dst_m[c];
            req_num_bytes_i[c*LW +: LW] = len_m[c];
        end
    endtask

    task automatic chk_desc(input string tag, input int w);
        chk({tag, "_src"}, dma_src_addr_o, src_m[w]);
        chk({tag, "_dst"}, dma_dst_addr_o, dst_m[w]);
        chk({tag, "_len"}, dma_num_bytes_o, len_m[w]);
    endtask

    // One descriptor from request to completion. lat = WAIT cycle (0-based) in which status is raised;
    // stale = done already high from the previous transfer; hold = leave done high afterwards.
    task automatic run_txn(input logic [NCH-1:0] vmask, input int lat, input bit e, input bit d,
                           input bit stale, input bit hold, output int gid);
        int  w, k_exp;
        bit  exp_err, exp_tmo;
        @(negedge clk);
        req_valid_i = vmask;
        drive_payloads();
        dma_done_i  = stale;
        dma_error_i = 1'b0;
        #1;
        w = model_winner(vmask, rr_m);
        chk("idle_ready", req_ready_o, 64'(1) << w);
        chk("idle_busy", busy_o, 0);
        chk("idle_go", dma_go_o, 0);
        chk("idle_cpl", cpl_valid_o, 0);
        rr_m = (w + 1) % NCH;
        @(negedge clk);
        req_valid_i = '0;
        #1;
        gid = int'(grant_id_o);
        chk("grant_id", grant_id_o, w);
        chk("post_ready", req_ready_o, 0);
        chk("post_busy", busy_o, 1);
        chk_desc("launch", w);
        if (len_m[w] == 0) begin
            chk("zero_go", dma_go_o, 0);
            chk("zero_cpl", cpl_valid_o, 64'(1) << w);
            chk("zero_err", cpl_error_o, 1);
            chk("zero_tmo", cpl_timeout_o, 0);
            dma_done_i = hold;
            return;
        end
        chk("launch_go", dma_go_o, 1);
        chk("launch_cpl", cpl_valid_o, 0);
        if (stale) begin
            k_exp = 0; exp_tmo = 0; exp_err = 0;
        end else if (TMO_EN && lat > TMO - 1) begin
            k_exp = TMO - 1; exp_tmo = 1; exp_err = 1;
        end else begin
            k_exp = lat; exp_tmo = 0; exp_err = e;
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            dma_done_i  = stale | ((k == lat) & d);
            dma_error_i = (k == lat) & e;
            #1;
            chk("wait_go", dma_go_o, 0);
            chk("wait_cpl", cpl_valid_o, 0);
            chk("wait_busy", busy_o, 1);
            if (k == k_exp) break;
            if (k == 63) chk("wait_bound", k, k_exp);
        end
        @(negedge clk);
        dma_done_i  = hold;
        dma_error_i = 1'b0;
        #1;
        chk("cpl_valid", cpl_valid_o, 64'(1) << w);
        chk("cpl_error", cpl_error_o, exp_err);
        chk("cpl_timeout", cpl_timeout_o, exp_tmo);
        chk("cpl_go", dma_go_o, 0);
        chk_desc("cpl", w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, st;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        tests = 0; fails = 0; rr_m = 0;
        rst = 1'b1; req_valid_i = '1; dma_done_i = 1'b0; dma_error_i = 1'b0;
        rand_payloads(0);
        drive_payloads();
        #1;
        chk("rst_ready", req_ready_o, 0);
        chk("rst_go", dma_go_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cpl", cpl_valid_o, 0);
        chk("rst_err", cpl_error_o, 0);
        chk("rst_tmo", cpl_timeout_o, 0);
        chk("rst_grant", grant_id_o, 0);
        chk("rst_src", dma_src_addr_o, 0);
        chk("rst_len", dma_num_bytes_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; req_valid_i = '0;

        // Single request on ch1, done 5 cycles after go.
        src_m[1] = 32'h1100_011b; dst_m[1] = 32'h1400_0127; len_m[1] = 32'h0000_000b;
        run_txn(4'b0010, 4, 1'b0, 1'b1, 1'b0, 1'b0, g);
        // Error and done together on ch2.
        rand_payloads(0);
        run_txn(4'b0100, 2, 1'b1, 1'b1, 1'b0, 1'b0, g);
        // Done left high into the next launch.
        rand_payloads(0);
        run_txn(4'b1000, 1, 1'b0, 1'b1, 1'b0, 1'b1, g);
        rand_payloads(0);
        run_txn(4'b0010, 3, 1'b0, 1'b1, 1'b1, 1'b0, g);
        // Zero-length descriptor on ch0.
        rand_payloads(0); len_m[0] = 0;
        run_txn(4'b0001, 0, 1'b0, 1'b1, 1'b0, 1'b0, g);

        for (int n = 0; n < 30; n++) begin
            rand_payloads(1);
            st = $urandom_range(0, 2);
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 5), st != 0, st != 1, 1'b0, 1'b0, g);
        end

`ifdef DMA_SCHED_TIMEOUT_EN
        rand_payloads(0);
        run_txn(4'b0100, 100, 1'b0, 1'b1, 1'b0, 1'b0, g);
        rand_payloads(0);
        run_txn(4'b0100, TMO - 1, 1'b0, 1'b1, 1'b0, 1'b0, g);
`endif

        // Reset asserted between clock edges while waiting on the engine.
        @(negedge clk);
        rand_payloads(0);
        drive_payloads();
        req_valid_i = '1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst_pre_busy", busy_o, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", req_ready_o, 0);
        chk("midrst_go", dma_go_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_cpl", cpl_valid_o, 0);
        chk("midrst_grant", grant_id_o, 0);
        chk("midrst_src", dma_src_addr_o, 0);
        chk("midrst_len", dma_num_bytes_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("midrst_hold_cpl", cpl_valid_o, 0);
            chk("midrst_hold_busy", busy_o, 0);
        end
        @(negedge clk);
        rst = 1'b0; req_valid_i = '0; rr_m = 0;

        // All channels valid: grants rotate from ch0 and wrap.
        for (int i = 0; i < 5; i++) begin
            rand_payloads(0);
            for (int c = 0; c < NCH; c++) len_m[c] = 32'h800;
            run_txn(4'b1111, 1, 1'b0, 1'b1, 1'b0, 1'b0, g);
            chk("rot_grant", g, order[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
